ifetch_queue: RTL and testbench

//  Instruction prefetch queue between instruction memory and cpu_2432 (upstream of the CPU fetch).

---
 rtl/ifetch_queue_if.sv | 24 ++
 rtl/ifetch_queue.sv | 133 +++++++++++++
 tb/tb_ifetch_queue.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_queue_if.sv
// Signal bundle between the instruction prefetch queue, the CPU fetch port and instruction memory.
// The queue side uses the master modport; the CPU/memory environment uses the slave modport.
interface ifetch_queue_if #(
  parameter int AW = 24,
  parameter int DW = 24
);
  logic [AW-1:0] i_cpu_iaddr;
  logic [DW-1:0] o_cpu_instr;
  logic          o_cpu_clk_en;
  logic          o_mem_req;
  logic [AW-1:0] o_mem_addr;
  logic          i_mem_ack;
  logic [DW-1:0] i_mem_data;

  modport master (
    input  i_cpu_iaddr, i_mem_ack, i_mem_data,
    output o_cpu_instr, o_cpu_clk_en, o_mem_req, o_mem_addr
  );

  modport slave (
    output i_cpu_iaddr, i_mem_ack, i_mem_data,
    input  o_cpu_instr, o_cpu_clk_en, o_mem_req, o_mem_addr
  );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: serves CPU fetches from a circular buffer of sequential words,
// stalls the CPU on a miss and refills from slower instruction memory, one request at a time.
module ifetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 24,
  parameter int DW    = 24
) (
  input  logic           i_clk,
  input  logic           i_rstb,
  ifetch_queue_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW-1:0] fetch_q, fetch_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          discard_q, discard_d;
  logic          mem_req_q, mem_req_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] entry_q [DEPTH];

  logic [AW-1:0] off;
  logic          hit, pend, flush;
  logic [CW-1:0] adv;
  logic [PW-1:0] hit_idx, wr_idx;
  logic          ack_seen, accept;

  // Lookup: the queue always holds the words base .. base+count-1, so a single modular
  // subtraction tells hit, next-to-arrive (pend) or unrelated address (flush).
  always_comb begin
    off     = bus.i_cpu_iaddr - base_q;
    hit     = off < AW'(count_q);
    pend    = off == AW'(count_q);
    flush   = !hit && !pend;
    adv     = hit ? off[CW-1:0] : '0;
    hit_idx = rd_ptr_q + off[PW-1:0];
    wr_idx  = rd_ptr_q + count_q[PW-1:0];
  end

  assign bus.o_cpu_clk_en = hit;
  assign bus.o_cpu_instr  = hit ? entry_q[hit_idx] : '0;
  assign bus.o_mem_req    = mem_req_q;
  assign bus.o_mem_addr   = mem_addr_q;

  // A flush in the same cycle as the ack wins: the returning word belongs to the old stream.
  assign ack_seen = (state_q == S_WAIT) && bus.i_mem_ack;
  assign accept   = ack_seen && !discard_q && !flush;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    discard_d  = discard_q;

    if (flush) begin
      base_d   = bus.i_cpu_iaddr;
      fetch_d  = bus.i_cpu_iaddr;
      count_d  = '0;
      rd_ptr_d = rd_ptr_q;
    end else begin
      base_d   = base_q + AW'(adv);
      fetch_d  = fetch_q + AW'(accept);
      count_d  = count_q - adv + CW'(accept);
      rd_ptr_d = rd_ptr_q + adv[PW-1:0];
    end

    unique case (state_q)
      S_IDLE: begin
        // Decide on next-cycle occupancy and address so a flush in this cycle requests the
        // new stream immediately instead of one stale word.
        if (count_d < CW'(DEPTH)) begin
          mem_req_d  = 1'b1;
          mem_addr_d = fetch_d;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.i_mem_ack) begin
          mem_req_d = 1'b0;
          discard_d = 1'b0;
          state_d   = S_IDLE;
        end else if (flush) begin
          discard_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rstb) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      fetch_q    <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      discard_q  <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      fetch_q    <= fetch_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      discard_q  <= discard_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  // NOTE: the entry storage is not reset; count=0 after reset makes its contents unreachable.
  always_ff @(posedge i_clk) begin
    if (i_rstb && accept) begin
      entry_q[wr_idx] <= bus.i_mem_data;
    end
  end

  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rstb)
    count_q <= CW'(DEPTH));

  a_addr_stable: assert property (@(posedge i_clk) disable iff (!i_rstb)
    (mem_req_q && !bus.i_mem_ack) |=> $stable(mem_addr_q));

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: a memory responder plus a queue-of-addresses reference
// model predicting CPU hit/instruction and memory request outputs every cycle.
module tb_ifetch_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 24;
  localparam int DW    = 24;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  always #5 clk = ~clk;

  ifetch_queue_if #(.AW(AW), .DW(DW)) bus ();

  ifetch_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .i_clk (clk),
    .i_rstb(rstb),
    .bus   (bus)
  );

  // stimulus controls
  logic [AW-1:0] cpu_addr = '0;
  bit            rst_drive = 1'b0;
  int            lat_min = 1, lat_max = 1;
  bit            spurious = 1'b0;
  bit            force_ack = 1'b0;

  // memory responder state
  bit mem_active = 1'b0;
  int mem_cnt = 0;

  // reference model: addresses currently held, next fetch address, outstanding request
  logic [AW-1:0] mq[$];
  logic [AW-1:0] m_fetch = '0, m_out_addr = '0;
  bit            m_busy = 1'b0, m_stale = 1'b0;

  logic          obs_en, obs_req, exp_en, exp_req;
  logic [DW-1:0] obs_instr, exp_instr;
  logic [AW-1:0] obs_addr, exp_addr;

  int n_checks = 0;
  int n_fails  = 0;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return a ^ 24'hA5A5A5;
  endfunction

  // One clock cycle: drive inputs after the falling edge, sample, predict, advance the model.
  task automatic step();
    logic          ack;
    logic [DW-1:0] data;
    int            idx;
    bit            hit, pend, flush, ack_now;
    @(negedge clk);
    ack  = 1'b0;
    data = DW'($urandom);
    if (!rst_drive) begin
      mem_active = 1'b0;
    end else begin
      if (bus.o_mem_req && !mem_active) begin
        mem_active = 1'b1;
        mem_cnt    = $urandom_range(lat_max, lat_min);
      end
      if (mem_active) begin
        if (mem_cnt == 0) begin
          ack        = 1'b1;
          data       = mem_word(bus.o_mem_addr);
          mem_active = 1'b0;
        end else begin
          mem_cnt--;
        end
      end else if (spurious && !bus.o_mem_req && $urandom_range(7, 0) == 0) begin
        ack = 1'b1;
      end
    end
    if (force_ack) begin
      ack       = 1'b1;
      force_ack = 1'b0;
    end
    rstb            = rst_drive;
    bus.i_cpu_iaddr = cpu_addr;
    bus.i_mem_ack   = ack;
    bus.i_mem_data  = data;
    #1;
    obs_en    = bus.o_cpu_clk_en;
    obs_instr = bus.o_cpu_instr;
    obs_req   = bus.o_mem_req;
    obs_addr  = bus.o_mem_addr;

    idx = -1;
    foreach (mq[i]) if (mq[i] == cpu_addr) idx = i;
    hit       = (idx >= 0);
    exp_en    = hit;
    exp_instr = hit ? mem_word(mq[idx]) : '0;
    exp_req   = m_busy;
    exp_addr  = m_out_addr;

    if (!rst_drive) begin
      mq.delete();
      m_fetch    = '0;
      m_out_addr = '0;
      m_busy     = 1'b0;
      m_stale    = 1'b0;
    end else begin
      pend    = !hit && (cpu_addr == m_fetch);
      flush   = !hit && !pend;
      ack_now = ack && m_busy;
      if (hit) repeat (idx) void'(mq.pop_front());
      if (flush) begin
        mq.delete();
        m_fetch = cpu_addr;
        if (m_busy && !ack_now) m_stale = 1'b1;
      end
      if (ack_now) begin
        m_busy = 1'b0;
        if (!m_stale && !flush) begin
          mq.push_back(m_out_addr);
          m_fetch = m_fetch + 1'b1;
        end
        m_stale = 1'b0;
      end else if (!m_busy && mq.size() < DEPTH) begin
        m_busy     = 1'b1;
        m_out_addr = m_fetch;
      end
    end
  endtask

  task automatic test_reset();
    rst_drive = 1'b0;
    cpu_addr  = '0;
    step();
    step();
    n_checks++;
    if ({obs_en, obs_req} !== 2'b00) begin
      n_fails++;
      $display("FAIL reset_ctl: got en=%0b req=%0b, expected en=0 req=0", obs_en, obs_req);
    end
    n_checks++;
    if (obs_addr !== '0) begin
      n_fails++;
      $display("FAIL reset_mem_addr: got %h, expected 000000", obs_addr);
    end
    n_checks++;
    if (obs_instr !== '0) begin
      n_fails++;
      $display("FAIL reset_instr: got %h, expected 000000", obs_instr);
    end
  endtask

  task automatic test_fill();
    int first_req = -1, first_en = -1;
    logic [AW-1:0] req_addr = 'x;
    logic [DW-1:0] en_instr = 'x;
    lat_min = 2; lat_max = 2; spurious = 1'b0;
    cpu_addr = '0;
    rst_drive = 1'b0; step(); rst_drive = 1'b1;
    for (int c = 0; c < 30; c++) begin
      step();
      n_checks++;
      if ({obs_en, obs_instr, obs_req, obs_addr} !== {exp_en, exp_instr, exp_req, exp_addr}) begin
        n_fails++;
        $display("FAIL fill_c%0d: got en=%0b instr=%h req=%0b addr=%h, expected en=%0b instr=%h req=%0b addr=%h",
                 c, obs_en, obs_instr, obs_req, obs_addr, exp_en, exp_instr, exp_req, exp_addr);
      end
      if (obs_req && first_req < 0) begin first_req = c; req_addr = obs_addr; end
      if (obs_en && first_en < 0) begin first_en = c; en_instr = obs_instr; end
    end
    n_checks++;
    if (first_req !== 1 || req_addr !== 24'h000000) begin
      n_fails++;
      $display("FAIL fill_first_req: got cycle %0d addr %h, expected cycle 1 addr 000000", first_req, req_addr);
    end
    n_checks++;
    if (first_en !== 4 || en_instr !== 24'hA5A5A5) begin
      n_fails++;
      $display("FAIL fill_first_hit: got cycle %0d instr %h, expected cycle 4 instr a5a5a5", first_en, en_instr);
    end
    n_checks++;
    if (obs_req !== 1'b0) begin
      n_fails++;
      $display("FAIL fill_full_req: got req=%0b, expected 0 with queue full", obs_req);
    end
  endtask

  task automatic test_sequential();
    int c = 0, last_en = -1;
    lat_min = 0; lat_max = 0;
    cpu_addr = '0;
    rst_drive = 1'b0; step(); rst_drive = 1'b1;
    while (cpu_addr < 16 && c < 200) begin
      step();
      n_checks++;
      if ({obs_en, obs_instr, obs_req, obs_addr} !== {exp_en, exp_instr, exp_req, exp_addr}) begin
        n_fails++;
        $display("FAIL seq_c%0d: got en=%0b instr=%h req=%0b addr=%h, expected en=%0b instr=%h req=%0b addr=%h",
                 c, obs_en, obs_instr, obs_req, obs_addr, exp_en, exp_instr, exp_req, exp_addr);
      end
      if (obs_en) begin
        n_checks++;
        if (obs_instr !== mem_word(cpu_addr)) begin
          n_fails++;
          $display("FAIL seq_instr@%h: got %h, expected %h", cpu_addr, obs_instr, mem_word(cpu_addr));
        end
        last_en  = c;
        cpu_addr = cpu_addr + 1'b1;
      end
      c++;
    end
    n_checks++;
    if (last_en !== 32) begin
      n_fails++;
      $display("FAIL seq_rate: last word 15 delivered at cycle %0d, expected 32", last_en);
    end
  endtask

  task automatic test_flush_in_wait();
    int c = 0, first_en = -1;
    bit armed = 1'b0;
    logic [AW-1:0] req_at4 = 'x;
    logic [DW-1:0] en_instr = 'x;
    logic          req4 = 1'b0;
    lat_min = 3; lat_max = 3;
    cpu_addr = '0;
    rst_drive = 1'b0; step(); rst_drive = 1'b1;
    while (!armed && c < 200) begin
      step();
      n_checks++;
      if ({obs_en, obs_instr, obs_req, obs_addr} !== {exp_en, exp_instr, exp_req, exp_addr}) begin
        n_fails++;
        $display("FAIL jump_pre_c%0d: got en=%0b instr=%h req=%0b addr=%h, expected en=%0b instr=%h req=%0b addr=%h",
                 c, obs_en, obs_instr, obs_req, obs_addr, exp_en, exp_instr, exp_req, exp_addr);
      end
      if (cpu_addr == 24'h3 && obs_req && obs_addr == 24'h5) armed = 1'b1;
      else if (cpu_addr < 24'h3 && obs_en) cpu_addr = cpu_addr + 1'b1;
      c++;
    end
    n_checks++;
    if (!armed) begin
      n_fails++;
      $display("FAIL jump_setup: request for 000005 with CPU at 000003 not seen within budget");
    end
    cpu_addr = 24'h100;
    for (int j = 0; j < 20; j++) begin
      step();
      n_checks++;
      if ({obs_en, obs_instr, obs_req, obs_addr} !== {exp_en, exp_instr, exp_req, exp_addr}) begin
        n_fails++;
        $display("FAIL jump_j%0d: got en=%0b instr=%h req=%0b addr=%h, expected en=%0b instr=%h req=%0b addr=%h",
                 j, obs_en, obs_instr, obs_req, obs_addr, exp_en, exp_instr, exp_req, exp_addr);
      end
      if (j == 4) begin req4 = obs_req; req_at4 = obs_addr; end
      if (obs_en && first_en < 0) begin first_en = j; en_instr = obs_instr; end
    end
    n_checks++;
    if (req4 !== 1'b1 || req_at4 !== 24'h000100) begin
      n_fails++;
      $display("FAIL jump_new_req: got req=%0b addr=%h, expected req=1 addr 000100", req4, req_at4);
    end
    n_checks++;
    if (first_en !== 8 || en_instr !== mem_word(24'h100)) begin
      n_fails++;
      $display("FAIL jump_hit: got cycle %0d instr %h, expected cycle 8 instr %h", first_en, en_instr, mem_word(24'h100));
    end
  endtask

  task automatic test_hit_advance();
    int c = 0;
    lat_min = 1; lat_max = 1;
    cpu_addr = 24'h10;
    rst_drive = 1'b0; step(); rst_drive = 1'b1;
    while (mq.size() < DEPTH && c < 100) begin
      step();
      n_checks++;
      if ({obs_en, obs_instr, obs_req, obs_addr} !== {exp_en, exp_instr, exp_req, exp_addr}) begin
        n_fails++;
        $display("FAIL adv_fill_c%0d: got en=%0b instr=%h req=%0b addr=%h, expected en=%0b instr=%h req=%0b addr=%h",
                 c, obs_en, obs_instr, obs_req, obs_addr, exp_en, exp_instr, exp_req, exp_addr);
      end
      c++;
    end
    cpu_addr = 24'h13;
    step();
    n_checks++;
    if ({obs_en, obs_instr, obs_req} !== {1'b1, mem_word(24'h13), 1'b0}) begin
      n_fails++;
      $display("FAIL adv_hit: got en=%0b instr=%h req=%0b, expected en=1 instr=%h req=0",
               obs_en, obs_instr, obs_req, mem_word(24'h13));
    end
    step();
    n_checks++;
    if ({obs_req, obs_addr} !== {1'b1, 24'h000014}) begin
      n_fails++;
      $display("FAIL adv_next_req: got req=%0b addr=%h, expected req=1 addr 000014", obs_req, obs_addr);
    end
  endtask

  task automatic test_wrap();
    int c = 0;
    bit saw_top = 1'b0, saw_zero = 1'b0;
    lat_min = 1; lat_max = 2;
    cpu_addr = 24'hFFFFFE;
    rst_drive = 1'b0; step(); rst_drive = 1'b1;
    while (cpu_addr != 24'h000003 && c < 400) begin
      step();
      n_checks++;
      if ({obs_en, obs_instr, obs_req, obs_addr} !== {exp_en, exp_instr, exp_req, exp_addr}) begin
        n_fails++;
        $display("FAIL wrap_c%0d: got en=%0b instr=%h req=%0b addr=%h, expected en=%0b instr=%h req=%0b addr=%h",
                 c, obs_en, obs_instr, obs_req, obs_addr, exp_en, exp_instr, exp_req, exp_addr);
      end
      if (obs_en && obs_instr === mem_word(cpu_addr)) begin
        if (cpu_addr == 24'hFFFFFF) saw_top = 1'b1;
        if (cpu_addr == 24'h000000) saw_zero = 1'b1;
      end
      // slow consumer so the queue runs ahead across the wrap point
      if (obs_en && $urandom_range(2, 0) == 0) cpu_addr = cpu_addr + 1'b1;
      c++;
    end
    n_checks++;
    if ({saw_top, saw_zero} !== 2'b11) begin
      n_fails++;
      $display("FAIL wrap_hits: got ffffff=%0b 000000=%0b, expected both delivered", saw_top, saw_zero);
    end
  endtask

  task automatic test_reset_mid_request();
    int c = 0;
    lat_min = 4; lat_max = 4;
    cpu_addr = '0;
    rst_drive = 1'b0; step(); rst_drive = 1'b1;
    do begin step(); c++; end while (!obs_req && c < 20);
    rst_drive = 1'b0;
    step();
    rst_drive = 1'b1;
    force_ack = 1'b1;
    step();
    n_checks++;
    if ({obs_en, obs_req} !== 2'b00) begin
      n_fails++;
      $display("FAIL rstmid_release: got en=%0b req=%0b, expected en=0 req=0", obs_en, obs_req);
    end
    step();
    n_checks++;
    if ({obs_en, obs_req, obs_addr} !== {1'b0, 1'b1, 24'h000000}) begin
      n_fails++;
      $display("FAIL rstmid_rereq: got en=%0b req=%0b addr=%h, expected en=0 req=1 addr 000000",
               obs_en, obs_req, obs_addr);
    end
    for (int j = 0; j < 12; j++) begin
      step();
      n_checks++;
      if ({obs_en, obs_instr, obs_req, obs_addr} !== {exp_en, exp_instr, exp_req, exp_addr}) begin
        n_fails++;
        $display("FAIL rstmid_j%0d: got en=%0b instr=%h req=%0b addr=%h, expected en=%0b instr=%h req=%0b addr=%h",
                 j, obs_en, obs_instr, obs_req, obs_addr, exp_en, exp_instr, exp_req, exp_addr);
      end
    end
  endtask

  task automatic test_random();
    int r;
    lat_min = 1; lat_max = 3; spurious = 1'b1;
    rst_drive = 1'b0; step(); rst_drive = 1'b1;
    cpu_addr = DW'($urandom);
    for (int c = 0; c < 1500; c++) begin
      r = $urandom_range(99, 0);
      if (!rst_drive) rst_drive = 1'b1;
      else if (r < 2) rst_drive = 1'b0;
      step();
      n_checks++;
      if ({obs_en, obs_instr, obs_req, obs_addr} !== {exp_en, exp_instr, exp_req, exp_addr}) begin
        n_fails++;
        $display("FAIL rand_c%0d: got en=%0b instr=%h req=%0b addr=%h, expected en=%0b instr=%h req=%0b addr=%h",
                 c, obs_en, obs_instr, obs_req, obs_addr, exp_en, exp_instr, exp_req, exp_addr);
      end
      r = $urandom_range(99, 0);
      if (obs_en && r < 60)  cpu_addr = cpu_addr + 1'b1;
      else if (r < 70)       cpu_addr = cpu_addr + AW'($urandom_range(4, 0));
      else if (r < 73)       cpu_addr = AW'($urandom);
      else if (r < 75)       cpu_addr = 24'hFFFFFC + AW'($urandom_range(3, 0));
    end
    spurious = 1'b0;
  endtask

  initial begin
    bus.i_cpu_iaddr = '0;
    bus.i_mem_ack   = 1'b0;
    bus.i_mem_data  = '0;
    test_reset();
    test_fill();
    test_sequential();
    test_flush_in_wait();
    test_hit_advance();
    test_wrap();
    test_reset_mid_request();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
